// File: rtl/audio_out_tx.sv
// audio_out_tx: double-buffered per-channel sample bank streamed out as an MSB-first TDM frame.
// Optional build macro AUDIO_OUT_TX_CLEAR_EN zeroes the outgoing read bank on every commit.
module audio_out_tx #(
    parameter int CHANNELS = 16,
    parameter int SCK_DIV  = 2
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        in_we,
    input  logic [3:0]  in_addr,
    input  logic [15:0] in_audio,
    input  logic        swap,
    output logic        sck,
    output logic        ws,
    output logic        sd,
    output logic        frame_start,
    output logic        overrun
);
    localparam int SLOT_W = $clog2(CHANNELS);
    localparam int DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);
    localparam logic [4:0]        CH_LIM    = 5'(CHANNELS);

    logic              sck_q, sck_d;
    logic              ws_q, ws_d;
    logic              sd_q, sd_d;
    logic              frame_start_q, frame_start_d;
    logic              overrun_q, overrun_d;
    logic              pending_q, pending_d;
    logic              wr_sel_q, wr_sel_d;
    logic              started_q, started_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [15:0]       bank_q [2][CHANNELS];

    logic              div_wrap, sck_fall, boundary, commit, wr_valid, rd_sel;
    logic [SLOT_W-1:0] wr_slot;
    logic [15:0]       rd_word;

    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        sck_fall = div_wrap && sck_q;
        boundary = !started_q || (sck_fall && bit_q == 4'd0 && slot_q == SLOT_LAST);
        commit   = boundary && pending_q;
        wr_valid = in_we && ({1'b0, in_addr} < CH_LIM);
        wr_slot  = in_addr[SLOT_W-1:0];

        started_d     = 1'b1;
        frame_start_d = boundary;
        pending_d     = swap || (pending_q && !commit);
        overrun_d     = overrun_q || (swap && pending_q);
        wr_sel_d      = wr_sel_q ^ commit;
        div_d         = div_wrap ? '0 : div_q + DIV_W'(1);
        sck_d         = sck_q ^ div_wrap;
        bit_d         = bit_q;
        slot_d        = slot_q;
        ws_d          = ws_q;

        if (boundary) begin
            div_d  = '0;
            sck_d  = 1'b0;
            bit_d  = 4'd15;
            slot_d = '0;
            ws_d   = 1'b1;
        end else if (sck_fall) begin
            ws_d = 1'b0;
            if (bit_q == 4'd0) begin
                bit_d  = 4'd15;
                slot_d = slot_q + SLOT_W'(1);
            end else begin
                bit_d = bit_q - 4'd1;
            end
        end

        // A write on the commit edge targets the bank that is about to be read; forward it.
        rd_sel  = !wr_sel_d;
        rd_word = bank_q[rd_sel][slot_d];
        if (wr_valid && (wr_sel_q == rd_sel) && (wr_slot == slot_d)) begin
            rd_word = in_audio;
        end
        sd_d = (boundary || sck_fall) ? rd_word[bit_d] : sd_q;
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            sck_q         <= 1'b0;
            ws_q          <= 1'b0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            pending_q     <= 1'b0;
            wr_sel_q      <= 1'b0;
            started_q     <= 1'b0;
            div_q         <= '0;
            bit_q         <= 4'd15;
            slot_q        <= '0;
        end else begin
            sck_q         <= sck_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            pending_q     <= pending_d;
            wr_sel_q      <= wr_sel_d;
            started_q     <= started_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            slot_q        <= slot_d;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    bank_q[c][i] <= '0;
                end
            end
        end else begin
`ifdef AUDIO_OUT_TX_CLEAR_EN
            if (commit) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    bank_q[!wr_sel_q][i] <= '0;
                end
            end
`endif
            if (wr_valid) begin
                bank_q[wr_sel_q][wr_slot] <= in_audio;
            end
        end
    end

    assign sck         = sck_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;

endmodule
